// File: rtl/mem_map_pkg.sv
// Shared types and default memory map for the region router.
package mem_map_pkg;

  // Access permitted inside a region.
  typedef enum logic [1:0] {
    RW      = 2'd0,
    RD_ONLY = 2'd1,
    WR_ONLY = 2'd2
  } region_mode_t;

  // Router transaction state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Default three-region map: base inclusive, limit exclusive, byte addresses.
  localparam int DEF_REGIONS = 3;
  localparam logic [31:0] DEF_REGION_BASE [DEF_REGIONS] =
    '{32'h0000_0000, 32'h0000_0400, 32'h0001_4000};
  localparam logic [31:0] DEF_REGION_LIMIT [DEF_REGIONS] =
    '{32'h0000_0400, 32'h0001_4000, 32'h0002_0000};
  localparam region_mode_t DEF_REGION_MODE [DEF_REGIONS] =
    '{RW, RD_ONLY, WR_ONLY};

  // True when a region with this mode accepts the access direction.
  function automatic logic mode_allows(input region_mode_t mode, input logic we);
    case (mode)
      RW:      return 1'b1;
      RD_ONLY: return !we;
      WR_ONLY: return we;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/region_match.sv
// Combinational address decode: lowest-index matching region, its
// permission check and the word index relative to the region base.
module region_match
  import mem_map_pkg::*;
#(
  parameter int           N       = 32,
  parameter int           REGIONS = DEF_REGIONS,
  parameter int           IDX_W   = (REGIONS > 1) ? $clog2(REGIONS) : 1,
  parameter logic [N-1:0] REGION_BASE  [REGIONS] = DEF_REGION_BASE,
  parameter logic [N-1:0] REGION_LIMIT [REGIONS] = DEF_REGION_LIMIT,
  parameter region_mode_t REGION_MODE  [REGIONS] = DEF_REGION_MODE
) (
  input  logic [N-1:0]     addr,
  input  logic             we,
  output logic [IDX_W-1:0] idx,
  output logic             hit,
  output logic             mode_ok,
  output logic [N-1:0]     word_addr
);

  // Scan upward so the first (lowest) matching region wins on overlap.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that skips
    // an assignment in always_comb would otherwise infer a latch.
    idx       = '0;
    hit       = 1'b0;
    mode_ok   = 1'b0;
    word_addr = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (!hit && (addr >= REGION_BASE[i]) && (addr < REGION_LIMIT[i])) begin
        hit       = 1'b1;
        idx       = IDX_W'(i);
        mode_ok   = mode_allows(REGION_MODE[i], we);
        word_addr = (addr - REGION_BASE[i]) >> 2;
      end
    end
  end

endmodule

// File: rtl/mem_region_router.sv
// Single-outstanding CPU-to-region router: decodes a request, drives one
// region until it acks or times out, then holds the response until taken.
module mem_region_router
  import mem_map_pkg::*;
#(
  parameter int           N       = 32,
  parameter int           REGIONS = DEF_REGIONS,
  parameter logic [N-1:0] REGION_BASE  [REGIONS] = DEF_REGION_BASE,
  parameter logic [N-1:0] REGION_LIMIT [REGIONS] = DEF_REGION_LIMIT,
  parameter region_mode_t REGION_MODE  [REGIONS] = DEF_REGION_MODE,
  parameter int           TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // CPU request channel
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [N-1:0]         req_addr,
  input  logic [N-1:0]         req_wdata,
  // CPU response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_rdata,
  output logic                 rsp_err,
  // Region bus
  output logic [REGIONS-1:0]   reg_sel,
  output logic                 reg_we,
  output logic [N-1:0]         reg_addr,
  output logic [N-1:0]         reg_wdata,
  input  logic [REGIONS*N-1:0] reg_rdata,
  input  logic [REGIONS-1:0]   reg_ack
);

  localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state_q, state_d;
  logic               out_of_reset_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               we_q;
  logic [N-1:0]       addr_q;
  logic [N-1:0]       wdata_q;
  logic [N-1:0]       rdata_q;
  logic               err_q;

  logic [IDX_W-1:0]   m_idx;
  logic               m_hit;
  logic               m_mode_ok;
  logic [N-1:0]       m_word_addr;

  logic [REGIONS-1:0] sel_onehot;
  logic               sel_ack;
  logic [N-1:0]       sel_rdata;
  logic               accept;
  logic               timeout_hit;

  region_match #(
    .N            (N),
    .REGIONS      (REGIONS),
    .IDX_W        (IDX_W),
    .REGION_BASE  (REGION_BASE),
    .REGION_LIMIT (REGION_LIMIT),
    .REGION_MODE  (REGION_MODE)
  ) u_match (
    .addr      (req_addr),
    .we        (req_we),
    .idx       (m_idx),
    .hit       (m_hit),
    .mode_ok   (m_mode_ok),
    .word_addr (m_word_addr)
  );

  // Pick the ack/rdata of the captured region only; other acks are ignored.
  always_comb begin
    sel_onehot = '0;
    sel_ack    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_ack       = reg_ack[i];
        sel_rdata     = reg_rdata[i*N +: N];
      end
    end
  end

  assign accept      = (state_q == IDLE) && out_of_reset_q && req_valid;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; an ack in the final counted cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (m_hit && m_mode_ok) ? ACCESS : RESP;
      ACCESS:  if (sel_ack || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holds req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_of_reset_q <= 1'b0;
    else        out_of_reset_q <= 1'b1;
  end

  // Request capture, access timeout counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            idx_q   <= m_idx;
            we_q    <= req_we;
            addr_q  <= m_word_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= !(m_hit && m_mode_ok);
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (sel_ack) begin
            rdata_q <= we_q ? '0 : sel_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Outputs are gated by state so everything but req_ready is 0 in IDLE.
  assign req_ready = (state_q == IDLE) && out_of_reset_q;
  assign reg_sel   = (state_q == ACCESS) ? sel_onehot : '0;
  assign reg_we    = (state_q == ACCESS) && we_q;
  assign reg_addr  = (state_q == ACCESS) ? addr_q  : '0;
  assign reg_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router with a response scoreboard.
module tb_mem_region_router;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  reg_sel;
  logic        reg_we;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [95:0] reg_rdata;
  logic [2:0]  reg_ack;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mem_region_router dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted response must match the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b want none", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err",   64'(rsp_err),   64'(e.err));
      end
    end
  end

  // One transaction: ack_cyc is the 0-based ACCESS cycle carrying ack_bits
  // (-1 for none); stray bits are driven on every other ACCESS cycle;
  // lat is the cycle count from acceptance to rsp_valid.
  task automatic txn(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int ack_cyc, input logic [2:0] stray,
                     input logic [2:0] ack_bits, input logic [31:0] ack_rdata,
                     input logic [2:0] exp_sel, input logic [31:0] exp_addr, input int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    reg_rdata = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    for (int i = 0; i < 3; i++) if (exp_sel[i]) reg_rdata[i*32 +: 32] = ack_rdata;
    @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    for (int c = 1; c < lat; c++) begin
      reg_ack = ((c - 1) == ack_cyc) ? ack_bits : stray;
      @(negedge clk);
      check({name, "_access"}, {60'd0, rsp_valid, reg_sel}, {60'd0, 1'b0, exp_sel});
      if (c == 1) begin
        check({name, "_reg_addr"}, 64'(reg_addr), 64'(exp_addr));
        check({name, "_reg_wr"}, {31'd0, reg_we, reg_wdata}, {31'd0, we, wdata});
      end
      step();
    end
    reg_ack = 3'b000;
    @(negedge clk);
    check({name, "_rsp_valid"}, {61'd0, rsp_valid, req_ready, |reg_sel}, {61'd0, 1'b1, 1'b0, 1'b0});
    step();
    @(negedge clk);
    check({name, "_back_idle"}, {62'd0, req_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    reg_rdata = '0;
    reg_ack   = '0;

    // Reset state and release timing of req_ready.
    @(negedge clk);
    @(negedge clk);
    check("rst_outputs", {56'd0, req_ready, rsp_valid, rsp_err, reg_we, 1'b0, reg_sel},
                         64'd0);
    check("rst_buses", 64'(reg_addr | reg_wdata | rsp_rdata), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_clk", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    check("rel_ready_after_clk", 64'(req_ready), 64'd1);
    step();

    // Region 0 read acked on first ACCESS cycle: word index 'h10>>2 = 4.
    expect_rsp(32'h0000_CAFE, 1'b0);
    txn("rd_r0", 1'b0, 32'h10, 32'h0, 0, 3'b000, 3'b001, 32'h0000_CAFE, 3'b001, 32'd4, 2);

    // Write into RD_ONLY region: error response one cycle after acceptance.
    expect_rsp(32'h0, 1'b1);
    txn("wr_rdonly", 1'b1, 32'h404, 32'h77, -1, 3'b000, 3'b000, 32'h0, 3'b000, 32'd0, 1);

    // Write region 2: (14008-14000)>>2 = 2; stray region-0 acks ignored.
    expect_rsp(32'h0, 1'b0);
    txn("wr_r2", 1'b1, 32'h14008, 32'h55, 2, 3'b001, 3'b100, 32'h99, 3'b100, 32'd2, 4);

    // Top of region 0, low bits ignored: 'h3FF>>2 = 'hFF.
    expect_rsp(32'h0BAD_F00D, 1'b0);
    txn("rd_r0_top", 1'b0, 32'h3FF, 32'h0, 1, 3'b000, 3'b001, 32'h0BAD_F00D, 3'b001, 32'hFF, 3);

    // Read from WR_ONLY region at its base: error.
    expect_rsp(32'h0, 1'b1);
    txn("rd_wronly", 1'b0, 32'h14000, 32'h0, -1, 3'b000, 3'b000, 32'h0, 3'b000, 32'd0, 1);

    // Last word of WR_ONLY region: (1FFFC-14000)>>2 = 'h2FFF.
    expect_rsp(32'h0, 1'b0);
    txn("wr_r2_top", 1'b1, 32'h1FFFC, 32'hA5A5_0001, 0, 3'b000, 3'b100, 32'h0, 3'b100, 32'h2FFF, 2);

    // Region 1 read with no ack: timeout error after exactly 15 ACCESS cycles.
    expect_rsp(32'h0, 1'b1);
    txn("rd_r1_timeout", 1'b0, 32'h400, 32'h0, -1, 3'b101, 3'b000, 32'h1111, 3'b010, 32'd0, 16);

    // Ack on the 15th ACCESS cycle wins over timeout: (800-400)>>2 = 'h100.
    expect_rsp(32'h0000_1234, 1'b0);
    txn("rd_r1_lastack", 1'b0, 32'h800, 32'h0, 14, 3'b101, 3'b010, 32'h1234, 3'b010, 32'h100, 16);

    // Unmapped read with response back-pressured for 5 cycles.
    expect_rsp(32'h0, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h20000;
    step();
    req_addr  = 32'h10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_rsp", {28'd0, rsp_valid, rsp_err, req_ready, |reg_sel, rsp_rdata},
                        {28'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check("hold_back_idle", {62'd0, req_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
    step();

    // Reset mid-ACCESS, then a stray ack: no response, outputs quiet.
    req_valid = 1'b1;
    req_addr  = 32'h10;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_access", 64'(reg_sel), 64'd1);
    #1 rst_n = 1'b0;
    reg_ack  = 3'b001;
    #1;
    check("abort_async", {61'd0, |reg_sel, req_ready, rsp_valid}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_low", {62'd0, req_ready, rsp_valid}, 64'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_idle", {59'd0, rsp_valid, reg_sel, req_ready}, {59'd0, 1'b0, 3'b000, 1'b1});
      step();
    end
    reg_ack = 3'b000;

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_region_router.md
MEM_REGION_ROUTER -- requirements
Module: mem_region_router

Interface
REQ-001 SHALL have parameter N, default 32: address and data width.
REQ-002 SHALL have parameter REGIONS, default 3: number of decoded regions.
REQ-003 SHALL have parameter REGION_BASE, default {'h0,'h400,'h14000}: inclusive byte base per region.
REQ-004 SHALL have parameter REGION_LIMIT, default {'h400,'h14000,'h20000}: exclusive byte limit per region.
REQ-005 SHALL have parameter REGION_MODE, default {RW,RD_ONLY,WR_ONLY}: permitted access per region.
REQ-006 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles without ack.
REQ-007 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in N, req_wdata in N: CPU request channel.
REQ-010 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out N, rsp_err out 1: CPU response channel.
REQ-011 SHALL have ports reg_sel out REGIONS (one-hot), reg_we out 1, reg_addr out N (word index), reg_wdata out N: region request bus.
REQ-012 SHALL have ports reg_rdata in REGIONS*N (region i at bits i*N +: N), reg_ack in REGIONS: region response.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-014 IDLE: req_ready=1; all other outputs 0; on req_valid, capture we/addr/wdata and decode.
REQ-015 Decode SHALL select the lowest index i with REGION_BASE[i] <= addr < REGION_LIMIT[i].
REQ-016 No match, write to RD_ONLY, or read from WR_ONLY SHALL go to RESP with rsp_err=1, rsp_rdata=0 (rsp_valid the cycle after acceptance).
REQ-017 Legal match SHALL go to ACCESS with reg_addr=(addr-REGION_BASE[i])>>2, low two address bits ignored.
REQ-018 ACCESS: reg_sel[i]=1, reg_we/reg_addr/reg_wdata stable, req_ready=0, timeout counter increments each cycle from 0.
REQ-019 reg_ack[i] in ACCESS SHALL go to RESP with rsp_err=0; reads capture reg_rdata[i], writes set rsp_rdata=0.
REQ-020 Counter reaching TIMEOUT without ack SHALL go to RESP with rsp_err=1, rsp_rdata=0; the ack cycle takes priority over timeout.
REQ-021 reg_ack from non-selected regions, or outside ACCESS, SHALL be ignored.
REQ-022 RESP: rsp_valid=1, rsp_rdata/rsp_err held until rsp_ready=1, then IDLE next cycle; req_ready=0 throughout.
REQ-023 Minimum latency SHALL be: acceptance cycle t, ACCESS at t+1, ack at t+1 gives rsp_valid at t+2.
REQ-024 The block SHALL have one outstanding transaction; no request accepted outside IDLE.
REQ-025 reg_sel SHALL never have more than one bit set.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, counter 0, and all outputs 0 except req_ready.
REQ-027 req_ready SHALL be 0 while rst_n is low, then 1 from the first clock after release.
REQ-028 Reset during ACCESS or RESP SHALL abort the transaction; no response is ever issued for it.

Structure
REQ-029 A package mem_map_pkg SHALL hold the region_mode_t enum (RW, RD_ONLY, WR_ONLY), the state_t enum, and default region constants.
REQ-030 One sub-module, region_match, SHALL hold the combinational decode (addr -> index, hit, mode_ok); the FSM and registers live in the top module.

Verification
REQ-031 Read 'h10, region0 ack at t+1 with rdata 'hCAFE -> reg_sel=3'b001, reg_addr=4, rsp_valid at t+2, rsp_rdata='hCAFE, err=0.
REQ-032 Write 'h404 (RD_ONLY) -> reg_sel stays 0, rsp_valid at t+1, rsp_err=1.
REQ-033 Write 'h14008 data 'h55 -> reg_sel=3'b100, reg_addr=2, reg_wdata='h55; ack after 3 cycles gives err=0.
REQ-034 Read 'h400 with no ack -> rsp_err=1 after exactly TIMEOUT=15 ACCESS cycles.
REQ-035 Read 'h20000 (unmapped) with rsp_ready held 0 for 5 cycles -> rsp_valid and err=1 held stable for 5 cycles, req_ready=0.
REQ-036 rst_n low mid-ACCESS, then a stray ack -> no rsp_valid, reg_sel=0, IDLE.
